stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
Button/mode sequencer for the stopwatch counter datapath. Debounces and edge-detects the raw Start/Stop/Clear/Lap buttons and samples the Countdown/TimeSet switches. A single registered FSM issues clean, single-clock-domain command strobes and level enables to the digit counters and display latch. It replaces all multi-edge and level-sensitive control with one synchronous controller. It also owns the expiry flash timing.

Parameters:
DB_CYCLES, 16, consecutive stable clk cycles needed before a button level is accepted (min 2)
FLASH_TICKS, 5, tick pulses per half-period of the expiry flash (5 ticks = 0.5 s)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tick  input  1  one-cycle 0.1 s timebase enable
Start  input  1  raw start button
Stop  input  1  raw stop button
Clear  input  1  raw clear button
Lap  input  1  raw lap button
Countdown  input  1  mode switch: 1 = count down
TimeSet  input  1  time-set switch
expired  input  1  datapath terminal count (9:59.9 up or 0:00.0 down), level
run_en  output  1  counter advances one tenth per tick
fast_en  output  1  counter advances one second per tick (set mode)
load_preset  output  1  one-cycle strobe: load 9:59.9
clear_cnt  output  1  one-cycle strobe: load 0:00.0
lap_hold  output  1  freeze display register
flash_blank  output  1  blank display anodes
state  output  3  current FSM state code

Behaviour:
- Reset (async, active-high): state=IDLE. All outputs 0. Debouncers, flash counter and preset_done flag cleared. Release takes effect on the next clk edge.
- Inputs: each button and switch passes through a 2-FF synchroniser. Buttons then go through a debounce counter: the debounced level updates only after DB_CYCLES equal samples. A press is a one-cycle pulse on the debounced rising edge. Switches are used synchronised, without debounce.
- Simultaneous presses in one cycle are prioritised clear > stop > start > lap. Lower-priority presses are dropped.
- expired=1 overrides any press in the same cycle in RUN and LAP.
- All outputs are registered. A transition is taken on the clk edge after the press pulse, and its outputs are visible on that same edge.
- States and codes: IDLE=0, RUN=1, LAP=2, PAUSED=3, SET=4, DONE=5. Codes 6 and 7 recover to IDLE.
- IDLE:
  - Start press → RUN. If Countdown=1 and preset_done=0, pulse load_preset and set preset_done.
  - Clear press → pulse clear_cnt, clear preset_done, stay in IDLE.
  - TimeSet=1 → SET.
- RUN: run_en=1.
  - Stop press → PAUSED.
  - Lap press with Countdown=0 → LAP. Lap press with Countdown=1 is ignored.
  - Clear press → pulse clear_cnt, clear preset_done, go to IDLE.
  - expired → DONE.
- LAP: run_en=1, lap_hold=1.
  - Start press → RUN.
  - Stop press → PAUSED, lap_hold=0.
  - Clear press → IDLE with clear_cnt pulse.
  - expired → DONE.
- PAUSED: run_en=0.
  - Start press → RUN.
  - Clear press → IDLE with clear_cnt pulse, preset_done cleared.
  - TimeSet is ignored.
- SET: fast_en = debounced Start level. Start presses do not leave SET.
  - TimeSet=0 → IDLE and set preset_done, so a set value is not overwritten by the preset.
  - Clear press → pulse clear_cnt, stay in SET.
- DONE: run_en=0.
  - flash_blank toggles after every FLASH_TICKS tick pulses. It starts at 0 and its first rise comes FLASH_TICKS ticks after entry.
  - Stop press → IDLE, flash_blank=0.
  - Clear press → IDLE, flash_blank=0, clear_cnt pulse, preset_done cleared.
  - Start press is ignored.
- Countdown changing in RUN, LAP or PAUSED takes no action; the datapath reads Countdown directly for direction.
- The flash counter counts up to FLASH_TICKS-1 and then wraps to 0. It is held at 0 outside DONE.

Test Plan:
- Reset asserted mid-RUN, with no clk edge → state=0 and run_en=0 immediately. After release and a Start pulse held DB_CYCLES+3 cycles → state=1 and run_en=1.
- Stop bounced 1-0-1 with each level shorter than DB_CYCLES → no transition. Stop held stable for DB_CYCLES → RUN→PAUSED exactly once.
- Countdown=1, Start from IDLE → one load_preset pulse exactly 1 cycle wide, state=1. After Clear, a second Start → load_preset again.
- Count-up in RUN, Lap → state=2, lap_hold=1. Then Start → state=1, lap_hold=0. Lap with Countdown=1 → no change.
- RUN, expired=1 in the same cycle as a Stop pulse → DONE. With FLASH_TICKS=5, flash_blank rises on the 5th tick, falls on the 10th, rises on the 15th. Stop → IDLE, flash_blank=0.
- IDLE, TimeSet=1 → state=4. Holding Start → fast_en=1, releasing → fast_en=0. TimeSet=0 then Start with Countdown=1 → RUN with no load_preset pulse.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Button/mode sequencer for the stopwatch counter datapath. The raw Start,
// Stop, Clear and Lap buttons are synchronised, debounced and edge-detected
// into one-cycle press pulses; the Countdown and TimeSet switches are only
// synchronised. A single registered FSM turns those into clean command
// strobes and level enables for the digit counters and display latch, and
// times the display flash once the count has expired.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   tick         one-cycle 0.1 s timebase enable
//   Start/Stop/Clear/Lap   raw push buttons (may bounce)
//   Countdown    mode switch, 1 = count down
//   TimeSet      time-set switch
//   expired      datapath terminal count reached (level)
//   run_en       counter advances one tenth per tick
//   fast_en      counter advances one second per tick (set mode)
//   load_preset  one-cycle strobe: load 9:59.9
//   clear_cnt    one-cycle strobe: load 0:00.0
//   lap_hold     freeze display register
//   flash_blank  blank display anodes
//   state        current FSM state code
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
   parameter int DB_CYCLES   = 16,
   parameter int FLASH_TICKS = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       Start,
   input  logic       Stop,
   input  logic       Clear,
   input  logic       Lap,
   input  logic       Countdown,
   input  logic       TimeSet,
   input  logic       expired,
   output logic       run_en,
   output logic       fast_en,
   output logic       load_preset,
   output logic       clear_cnt,
   output logic       lap_hold,
   output logic       flash_blank,
   output logic [2:0] state
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] RUN    = 3'd1;
   localparam logic [2:0] LAP    = 3'd2;
   localparam logic [2:0] PAUSED = 3'd3;
   localparam logic [2:0] SET    = 3'd4;
   localparam logic [2:0] DONE   = 3'd5;

   // Bit positions of the buttons inside the packed button vectors.
   localparam int B_START = 0;
   localparam int B_STOP  = 1;
   localparam int B_CLEAR = 2;
   localparam int B_LAP   = 3;

   localparam int DBW = $clog2(DB_CYCLES);
   localparam int FW  = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
   localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_CYCLES - 1);
   localparam logic [FW-1:0]  FLASH_LAST = FW'(FLASH_TICKS - 1);

   logic [3:0]     btn_raw;
   logic [3:0]     btn_s1;
   logic [3:0]     btn_s2;
   logic [3:0]     btn_lvl;
   logic [3:0]     btn_lvl_q;
   logic [DBW-1:0] db_cnt [4];
   logic [1:0]     sw_s1;      // {TimeSet, Countdown}
   logic [1:0]     sw_s2;

   logic [3:0]     press;
   logic           clear_p;
   logic           stop_p;
   logic           start_p;
   logic           lap_p;
   logic           cd;
   logic           ts;

   logic [2:0]     state_nxt;
   logic           ld_nxt;
   logic           clr_nxt;
   logic           pd_nxt;
   logic           preset_done;
   logic [FW-1:0]  flash_cnt;

   assign btn_raw = {Lap, Clear, Stop, Start};

   // Two-flop synchronisers for every asynchronous input.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         btn_s1 <= '0;
         btn_s2 <= '0;
         sw_s1  <= '0;
         sw_s2  <= '0;
      end else begin
         btn_s1 <= btn_raw;
         btn_s2 <= btn_s1;
         sw_s1  <= {TimeSet, Countdown};
         sw_s2  <= sw_s1;
      end
   end

   // Debounce: the accepted level follows the synchronised sample only after
   // DB_CYCLES consecutive samples disagree with it. Any agreeing sample
   // restarts the count, so bounces shorter than DB_CYCLES are swallowed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: this small counter array is control state and must start known, so it is reset like any flop.
         for (int i = 0; i < 4; i++) begin
            db_cnt[i] <= '0;
         end
         btn_lvl   <= '0;
         btn_lvl_q <= '0;
      end else begin
         btn_lvl_q <= btn_lvl;
         for (int i = 0; i < 4; i++) begin
            if (btn_s2[i] == btn_lvl[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               btn_lvl[i] <= btn_s2[i];
               db_cnt[i]  <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // One-cycle pulse on each debounced rising edge, then priority masking:
   // clear > stop > start > lap, losers in the same cycle are dropped.
   assign press   = btn_lvl & ~btn_lvl_q;
   assign clear_p = press[B_CLEAR];
   assign stop_p  = press[B_STOP]  & ~press[B_CLEAR];
   assign start_p = press[B_START] & ~press[B_STOP] & ~press[B_CLEAR];
   assign lap_p   = press[B_LAP]   & ~(|press[B_CLEAR:B_START]);

   assign cd = sw_s2[0];
   assign ts = sw_s2[1];

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
      state_nxt = state;
      ld_nxt    = 1'b0;
      clr_nxt   = 1'b0;
      pd_nxt    = preset_done;
      case (state)
         IDLE: begin
            if (clear_p) begin
               clr_nxt = 1'b1;
               pd_nxt  = 1'b0;
            end else if (start_p) begin
               state_nxt = RUN;
               // Preset is loaded once per countdown; a set-mode value or a
               // resumed countdown must not be overwritten.
               if (cd && !preset_done) begin
                  ld_nxt = 1'b1;
                  pd_nxt = 1'b1;
               end
            end else if (ts) begin
               state_nxt = SET;
            end
         end
         RUN: begin
            if (expired) begin
               state_nxt = DONE;
            end else if (clear_p) begin
               state_nxt = IDLE;
               clr_nxt   = 1'b1;
               pd_nxt    = 1'b0;
            end else if (stop_p) begin
               state_nxt = PAUSED;
            end else if (lap_p && !cd) begin
               state_nxt = LAP;
            end
         end
         LAP: begin
            if (expired) begin
               state_nxt = DONE;
            end else if (clear_p) begin
               state_nxt = IDLE;
               clr_nxt   = 1'b1;
               pd_nxt    = 1'b0;
            end else if (stop_p) begin
               state_nxt = PAUSED;
            end else if (start_p) begin
               state_nxt = RUN;
            end
         end
         PAUSED: begin
            if (clear_p) begin
               state_nxt = IDLE;
               clr_nxt   = 1'b1;
               pd_nxt    = 1'b0;
            end else if (start_p) begin
               state_nxt = RUN;
            end
         end
         SET: begin
            if (clear_p) begin
               clr_nxt = 1'b1;
            end else if (!ts) begin
               state_nxt = IDLE;
               pd_nxt    = 1'b1;
            end
         end
         DONE: begin
            if (clear_p) begin
               state_nxt = IDLE;
               clr_nxt   = 1'b1;
               pd_nxt    = 1'b0;
            end else if (stop_p) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // All outputs are registered from the next state, so they change on the
   // same edge as the transition that causes them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         run_en      <= 1'b0;
         fast_en     <= 1'b0;
         load_preset <= 1'b0;
         clear_cnt   <= 1'b0;
         lap_hold    <= 1'b0;
         flash_blank <= 1'b0;
         preset_done <= 1'b0;
         flash_cnt   <= '0;
      end else begin
         state       <= state_nxt;
         run_en      <= (state_nxt == RUN) || (state_nxt == LAP);
         lap_hold    <= (state_nxt == LAP);
         fast_en     <= (state_nxt == SET) && btn_lvl[B_START];
         load_preset <= ld_nxt;
         clear_cnt   <= clr_nxt;
         preset_done <= pd_nxt;
         // Flash timing only runs while staying in DONE; entering or leaving
         // DONE restarts it with the display lit.
         if ((state == DONE) && (state_nxt == DONE)) begin
            if (tick) begin
               if (flash_cnt == FLASH_LAST) begin
                  flash_cnt   <= '0;
                  flash_blank <= ~flash_blank;
               end else begin
                  flash_cnt <= flash_cnt + 1'b1;
               end
            end
         end else begin
            flash_cnt   <= '0;
            flash_blank <= 1'b0;
         end
      end
   end

endmodule
